// File: rtl/cache_line_arbiter.sv
// cache_line_arbiter: N-channel cache-line requester arbiter in front of a
// single burst memory port. Each line moves as BEATS = LINE_W/BUS_W beats;
// grant selection is fixed-priority or round-robin, chosen by RR_MODE.
module cache_line_arbiter #(
    parameter int NUM_CH  = 2,
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 256,
    parameter int BUS_W   = 64,
    parameter int RR_MODE = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        ch_read,
    input  logic [NUM_CH-1:0]        ch_write,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    input  logic [NUM_CH*LINE_W-1:0] ch_wdata,
    output logic [LINE_W-1:0]        ch_rdata,
    output logic [NUM_CH-1:0]        ch_resp,
    output logic                     pmem_read,
    output logic                     pmem_write,
    output logic [ADDR_W-1:0]        pmem_addr,
    output logic [BUS_W-1:0]         pmem_wdata,
    input  logic [BUS_W-1:0]         pmem_rdata,
    input  logic                     pmem_resp
);

    localparam int          BEATS  = LINE_W / BUS_W;
    localparam int          BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int          CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int          OFF_W  = $clog2(LINE_W / 8);
    localparam int unsigned NCH    = NUM_CH;

    localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'((64'd1 << OFF_W) - 64'd1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BURST_RD,
        ST_BURST_WR,
        ST_DONE
    } state_t;

    state_t                              state_q;
    logic [CH_W-1:0]                     gnt_q;
    logic [CH_W-1:0]                     gnt_d;
    logic [CH_W-1:0]                     ptr_q;
    logic [BEAT_W-1:0]                   beat_q;
    logic [ADDR_W-1:0]                   addr_q;
    logic [BEATS-1:0][BUS_W-1:0]         wline_q;
    logic [BEATS-1:0][BUS_W-1:0]         rline_q;
    logic                                rd_q;
    logic                                wr_q;
    logic [NUM_CH-1:0]                   resp_q;
    logic [NUM_CH-1:0]                   req;
    logic                                any_req;
    logic [NUM_CH-1:0][ADDR_W-1:0]       addr_v;
    logic [NUM_CH-1:0][BEATS-1:0][BUS_W-1:0] wdata_v;

    assign addr_v  = ch_addr;
    assign wdata_v = ch_wdata;

    // Grant selection: first requester scanning upward from ptr (RR) or from 0 (fixed).
    always_comb begin
        logic            found;
        int unsigned     sum;
        logic [CH_W-1:0] cand;
        req     = ch_read | ch_write;
        any_req = |req;
        gnt_d   = '0;
        found   = 1'b0;
        sum     = 0;
        cand    = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            sum  = (RR_MODE != 0) ? (32'(ptr_q) + k) % NCH : k;
            cand = CH_W'(sum);
            if (!found && req[cand]) begin
                found = 1'b1;
                gnt_d = cand;
            end
        end
    end

    assign pmem_read  = rd_q;
    assign pmem_write = wr_q;
    assign pmem_addr  = addr_q;
    assign pmem_wdata = wline_q[beat_q];
    assign ch_rdata   = rline_q;
    assign ch_resp    = resp_q;

    // Burst FSM: latches the winning request, counts beats, pulses the response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
            beat_q  <= '0;
            addr_q  <= '0;
            wline_q <= '0;
            rline_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            resp_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        gnt_q   <= gnt_d;
                        addr_q  <= addr_v[gnt_d] & ADDR_MASK;
                        wline_q <= wdata_v[gnt_d];
                        beat_q  <= '0;
                        // A channel raising both read and write gets the write.
                        if (ch_write[gnt_d]) begin
                            state_q <= ST_BURST_WR;
                            wr_q    <= 1'b1;
                        end else begin
                            state_q <= ST_BURST_RD;
                            rd_q    <= 1'b1;
                        end
                    end
                end
                ST_BURST_RD, ST_BURST_WR: begin
                    if (pmem_resp) begin
                        if (state_q == ST_BURST_RD) begin
                            rline_q[beat_q] <= pmem_rdata;
                        end
                        beat_q <= beat_q + 1'b1;
                        if (beat_q == LAST_BEAT) begin
                            state_q       <= ST_DONE;
                            rd_q          <= 1'b0;
                            wr_q          <= 1'b0;
                            resp_q[gnt_q] <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    resp_q  <= '0;
                    state_q <= ST_IDLE;
                    if (RR_MODE != 0) begin
                        ptr_q <= (gnt_q == LAST_CH) ? '0 : gnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_line_arbiter.sv
// Directed bench: a 3-channel round-robin instance and a 2-channel
// fixed-priority instance share one hand-driven memory responder.
module tb_cache_line_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        mem_resp  = 1'b0;
    logic [63:0] mem_rdata = '0;

    // Round-robin instance, 3 channels
    logic [2:0]     r_ch_read  = '0;
    logic [2:0]     r_ch_write = '0;
    logic [95:0]    r_ch_addr  = '0;
    logic [767:0]   r_ch_wdata = '0;
    logic [255:0]   r_ch_rdata;
    logic [2:0]     r_ch_resp;
    logic           r_rd, r_wr;
    logic [31:0]    r_addr;
    logic [63:0]    r_wdata;

    // Fixed-priority instance, 2 channels
    logic [1:0]     f_ch_read  = '0;
    logic [1:0]     f_ch_write = '0;
    logic [63:0]    f_ch_addr  = '0;
    logic [511:0]   f_ch_wdata = '0;
    logic [255:0]   f_ch_rdata;
    logic [1:0]     f_ch_resp;
    logic           f_rd, f_wr;
    logic [31:0]    f_addr;
    logic [63:0]    f_wdata;

    cache_line_arbiter #(.NUM_CH(3), .ADDR_W(32), .LINE_W(256), .BUS_W(64), .RR_MODE(1)) u_rr (
        .clk(clk), .rst(rst),
        .ch_read(r_ch_read), .ch_write(r_ch_write), .ch_addr(r_ch_addr), .ch_wdata(r_ch_wdata),
        .ch_rdata(r_ch_rdata), .ch_resp(r_ch_resp),
        .pmem_read(r_rd), .pmem_write(r_wr), .pmem_addr(r_addr), .pmem_wdata(r_wdata),
        .pmem_rdata(mem_rdata), .pmem_resp(mem_resp)
    );

    cache_line_arbiter #(.NUM_CH(2), .ADDR_W(32), .LINE_W(256), .BUS_W(64), .RR_MODE(0)) u_fp (
        .clk(clk), .rst(rst),
        .ch_read(f_ch_read), .ch_write(f_ch_write), .ch_addr(f_ch_addr), .ch_wdata(f_ch_wdata),
        .ch_rdata(f_ch_rdata), .ch_resp(f_ch_resp),
        .pmem_read(f_rd), .pmem_write(f_wr), .pmem_addr(f_addr), .pmem_wdata(f_wdata),
        .pmem_rdata(mem_rdata), .pmem_resp(mem_resp)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic cmd(input int which);
        return (which != 0) ? (f_rd | f_wr) : (r_rd | r_wr);
    endfunction

    function automatic logic [31:0] cur_addr(input int which);
        return (which != 0) ? f_addr : r_addr;
    endfunction

    // Waits (bounded) for a command, returns 4 beats with dly idle cycles before
    // each, and reports the ch_resp seen in the completion cycle.
    task automatic serve(input int which, input int dly, input logic [63:0] base,
                         output logic [2:0] resp);
        int          n;
        logic [31:0] a0;
        logic        stable;
        n = 0;
        while (!cmd(which) && n < 8) begin
            step();
            n++;
        end
        chk("cmd_start", cmd(which), 1'b1);
        a0     = cur_addr(which);
        stable = 1'b1;
        for (int b = 0; b < 4; b++) begin
            for (int d = 0; d < dly; d++) begin
                step();
                if (!cmd(which) || cur_addr(which) != a0) stable = 1'b0;
            end
            mem_resp  = 1'b1;
            mem_rdata = base + 64'(b);
            step();
            mem_resp  = 1'b0;
        end
        if (dly > 0) chk("stall_hold", stable, 1'b1);
        resp = (which != 0) ? {1'b0, f_ch_resp} : r_ch_resp;
        chk("cmd_low_in_done", cmd(which), 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  resp;
        logic [63:0] wv [4];
        wv[0] = 64'hAAAA_0000_0000_000A;
        wv[1] = 64'hBBBB_0000_0000_000B;
        wv[2] = 64'hCCCC_0000_0000_000C;
        wv[3] = 64'hDDDD_0000_0000_000D;

        // Reset state
        step(); step();
        chk("rst_rd", r_rd, 1'b0);
        chk("rst_wr", r_wr, 1'b0);
        chk("rst_resp", r_ch_resp, 3'b000);
        chk("rst_rdata", r_ch_rdata, '0);
        chk("rst_f_cmd", f_rd | f_wr, 1'b0);
        rst = 1'b0;
        step();

        // Single read on channel 1, unaligned address
        r_ch_addr[32 +: 32] = 32'h0000_1234;
        r_ch_read = 3'b010;
        step();
        chk("rd_cmd", r_rd, 1'b1);
        chk("rd_addr", r_addr, 32'h0000_1220);
        serve(0, 0, 64'hA0, resp);
        chk("rd_resp", resp, 3'b010);
        chk("rd_data", r_ch_rdata, {64'hA3, 64'hA2, 64'hA1, 64'hA0});
        r_ch_read = '0;
        step();
        chk("rd_resp_1cyc", r_ch_resp, 3'b000);

        // Stalled memory read on channel 2
        r_ch_addr[64 +: 32] = 32'h0000_8040;
        r_ch_read = 3'b100;
        serve(0, 5, 64'hC0, resp);
        chk("stall_resp", resp, 3'b100);
        chk("stall_data", r_ch_rdata, {64'hC3, 64'hC2, 64'hC1, 64'hC0});
        r_ch_read = '0;
        step();
        chk("stall_idle", r_rd, 1'b0);

        // Single write on channel 0
        r_ch_addr[0 +: 32]    = 32'h0000_4000;
        r_ch_wdata[0 +: 256]  = {wv[3], wv[2], wv[1], wv[0]};
        r_ch_write = 3'b001;
        step();
        chk("wr_cmd", r_wr, 1'b1);
        chk("wr_rd_low", r_rd, 1'b0);
        chk("wr_addr", r_addr, 32'h0000_4000);
        for (int b = 0; b < 4; b++) begin
            chk("wr_beat", r_wdata, wv[b]);
            mem_resp = 1'b1;
            step();
            mem_resp = 1'b0;
        end
        chk("wr_resp", r_ch_resp, 3'b001);
        chk("wr_low_done", r_wr, 1'b0);
        chk("rdata_hold", r_ch_rdata, {64'hC3, 64'hC2, 64'hC1, 64'hC0});
        r_ch_write = '0;
        step();
        chk("wr_resp_1cyc", r_ch_resp, 3'b000);

        // Reset mid-burst after two beats (ptr is 1 at this point)
        r_ch_read = 3'b100;
        step();
        chk("mid_cmd", r_rd, 1'b1);
        for (int b = 0; b < 2; b++) begin
            mem_resp  = 1'b1;
            mem_rdata = 64'hE0 + 64'(b);
            step();
            mem_resp  = 1'b0;
        end
        rst = 1'b1;
        #1;
        chk("mid_rd_drop", r_rd, 1'b0);
        chk("mid_no_resp", r_ch_resp, 3'b000);
        step(); step();
        chk("mid_rdata_clr", r_ch_rdata, '0);
        chk("mid_no_resp2", r_ch_resp, 3'b000);
        r_ch_read = 3'b111;
        rst = 1'b0;

        // All channels request continuously: grants 0,1,2,0 from ptr 0
        serve(0, 0, 64'hB0, resp);
        chk("rr_g0", resp, 3'b001);
        chk("rr_beat0", r_ch_rdata, {64'hB3, 64'hB2, 64'hB1, 64'hB0});
        serve(0, 0, 64'h10, resp);
        chk("rr_g1", resp, 3'b010);
        serve(0, 0, 64'h20, resp);
        chk("rr_g2", resp, 3'b100);
        serve(0, 0, 64'h30, resp);
        chk("rr_g0_again", resp, 3'b001);
        r_ch_read = '0;
        step();

        // Fixed priority: channel 0 served twice before channel 1
        f_ch_read = 2'b11;
        serve(1, 0, 64'h50, resp);
        chk("fp_first", resp, 3'b001);
        serve(1, 0, 64'h60, resp);
        chk("fp_second", resp, 3'b001);
        chk("fp_data", f_ch_rdata, {64'h63, 64'h62, 64'h61, 64'h60});
        f_ch_read = 2'b10;
        serve(1, 0, 64'h70, resp);
        chk("fp_third", resp, 3'b010);
        f_ch_read = '0;
        step();
        chk("fp_idle", f_rd | f_wr, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cache_line_arbiter.md
# cache_line_arbiter

Parametrised N-channel arbiter that multiplexes cache-line read/write requests from several caches (instruction cache, data cache, later victim/prefetch buffers) onto the single burst physical-memory port exported at the CPU top level. Each requester sees a full-line, single-response interface. The memory side runs BEATS = LINE_W/BUS_W consecutive beats per line. Arbitration is fixed-priority or round-robin, selected by parameter. It replaces the hard-wired two-cache arbiter and sits between the L1 caches and the burst memory interface.

## Interface
- NUM_CH, 2: number of requesting channels (≥1; channel 0 = icache, 1 = dcache by convention).
- ADDR_W, 32: address width.
- LINE_W, 256: cache line width in bits.
- BUS_W, 64: memory burst beat width; LINE_W/BUS_W must be a power of two ≥1.
- RR_MODE, 1: 1 = round-robin, 0 = fixed priority (lowest index wins).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ch_read  in  NUM_CH  per-channel line read request, level, held until ch_resp.
- ch_write  in  NUM_CH  per-channel line write request, level, held until ch_resp.
- ch_addr  in  NUM_CH*ADDR_W  per-channel address, channel i at [i*ADDR_W +: ADDR_W].
- ch_wdata  in  NUM_CH*LINE_W  per-channel write line.
- ch_rdata  out  LINE_W  read line, shared by all channels; valid only with the owner's ch_resp.
- ch_resp  out  NUM_CH  one-cycle completion pulse to the granted channel.
- pmem_read  out  1  burst read, held for the whole burst.
- pmem_write  out  1  burst write, held for the whole burst.
- pmem_addr  out  ADDR_W  line-aligned address; low log2(LINE_W/8) bits forced to 0.
- pmem_wdata  out  BUS_W  current write beat.
- pmem_rdata  in  BUS_W  current read beat, valid when pmem_resp = 1.
- pmem_resp  in  1  one pulse per beat accepted or returned.

## Operation
- States:
  - IDLE: no burst in progress.
  - BURST_RD: read burst, memory side active.
  - BURST_WR: write burst, memory side active.
  - DONE: completion cycle.
- IDLE
  - A channel requests if ch_read[i] | ch_write[i].
  - On any request, select grant g: fixed mode takes the lowest requesting index; RR mode takes the first requesting index at or after ptr, with modulo-NUM_CH wrap.
  - Latch g, the line-aligned ch_addr[g] and ch_wdata[g]; clear the beat counter.
  - Go to BURST_WR if ch_write[g] = 1, else BURST_RD. If a channel asserts both requests, the write is served.
- BURST_RD / BURST_WR
  - Assert pmem_read or pmem_write, and pmem_addr = latched address.
  - pmem_wdata = latched line[beat*BUS_W +: BUS_W].
  - On each pmem_resp: read bursts store pmem_rdata into line buffer slot beat; the beat counter increments.
  - On pmem_resp with beat = BEATS-1, go to DONE.
- DONE
  - ch_resp[g] = 1 for this cycle only. ch_rdata = line buffer.
  - In RR mode, ptr ← (g+1) mod NUM_CH; fixed mode leaves ptr unused.
  - Go to IDLE.
- ch_rdata holds its value until the next read burst overwrites it.
- A requester that drops its request mid-burst does not abort the burst. The burst completes and ch_resp[g] still pulses.
- Requests from non-granted channels are ignored until the next IDLE cycle; nothing is queued.
- Reset: state → IDLE, ptr → 0, beat → 0, line buffer → 0. All outputs are 0 while rst is high, including mid-burst; pmem_read/write drop asynchronously.

## Timing
- A request first seen in IDLE at edge t drives pmem_read/write high from t (registered) until the edge on which the last beat is accepted.
- The last beat is accepted at edge u; ch_resp is high in the cycle after u (DONE).
- One mandatory IDLE cycle follows DONE. Requesters drop their request on the edge that ends DONE, so they are not re-granted.
- Minimum channel-to-channel turnaround: DONE plus IDLE, 2 cycles with no memory command.
- pmem_addr and pmem_wdata are stable while the command is high. pmem_wdata advances on the edge after each pmem_resp.
- No combinational path from ch_* inputs to pmem_* outputs; all memory-side outputs are register-driven.

## Test plan
- Single read, NUM_CH = 2: ch_read[1] = 1, addr 0x0000_1234, memory returns beats 0xA0..0xA3 → pmem_addr = 0x0000_1220; ch_resp[1] one cycle after the 4th beat; ch_rdata = {A3,A2,A1,A0}.
- Single write: ch_write[0] = 1, wdata = {D,C,B,A} 64-bit words → pmem_wdata presents A, B, C, D on successive pmem_resp; ch_resp[0] pulses once; pmem_write low in DONE.
- Round-robin fairness, RR_MODE = 1, NUM_CH = 3: all channels continuously request → grants 0, 1, 2, 0, …; no channel is starved.
- Fixed priority, RR_MODE = 0: channels 0 and 1 both request, channel 0 re-requests after its response → channel 0 is served twice before channel 1.
- Stalled memory: pmem_resp is delayed 5 cycles between beats → pmem_read stays high and pmem_addr stays stable; only 4 beats are accepted.
- Reset mid-burst after beat 2 → pmem_read drops immediately; no ch_resp; after release, a new request starts at beat 0 with ptr = 0.
